// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution input-buffer controller.
//   ibuf_ctrl_state_t : controller FSM state encoding
//   win_count()       : number of stride-1, unpadded KxK windows in an img x img image
package conv_pkg;

   typedef enum logic [0:0] {
      LOAD   = 1'b0,
      STREAM = 1'b1
   } ibuf_ctrl_state_t;

   function automatic int win_count(input int img, input int k);
      return (img - k + 1) * (img - k + 1);
   endfunction

endpackage

// File: rtl/conv_pos_counter.sv
// Raster position tracker for the input pixel stream.
//   clk, rst     : clock, synchronous active-high reset
//   fire         : a pixel is accepted this cycle
//   window_done  : this fire completes a KxK window (pre-increment position test)
//   img_end      : current position is the last pixel of the image
module conv_pos_counter
   import conv_pkg::*;
#(
   parameter int IMG_DIM    = 28,
   parameter int KERNEL_DIM = 3,
   parameter int POS_WIDTH  = (IMG_DIM <= 1) ? 1 : $clog2(IMG_DIM)
) (
   input  logic clk,
   input  logic rst,
   input  logic fire,
   output logic window_done,
   output logic img_end
);

   localparam logic [POS_WIDTH-1:0] LAST_POS = POS_WIDTH'(IMG_DIM - 1);
   localparam logic [POS_WIDTH-1:0] EDGE_POS = POS_WIDTH'(KERNEL_DIM - 1);

   logic [POS_WIDTH-1:0] row;
   logic [POS_WIDTH-1:0] col;

   assign img_end     = (row == LAST_POS) && (col == LAST_POS);
   assign window_done = fire && (row >= EDGE_POS) && (col >= EDGE_POS);

   always_ff @(posedge clk) begin
      if (rst) begin
         row <= '0;
         col <= '0;
      end else if (fire) begin
         if (col == LAST_POS) begin
            col <= '0;
            row <= (row == LAST_POS) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

endmodule

// File: rtl/conv_ibuf_ctrl.sv
// Sequencer for the convolution input buffer feeding the CIM tiles.
// Accepts raster-order pixels (all channels in parallel), drives the buffer
// shift enables, and for every complete KxK window walks the bit-plane index
// (outer) and slice address (inner) through a valid/ready handshake.
//   clk, rst        : clock, synchronous active-high reset
//   i_valid/o_ready : upstream pixel handshake
//   o_write_enable  : per-channel buffer shift enable (same cycle as accept)
//   o_count         : bit-plane select
//   o_ibuf_addr     : slice select
//   o_out_valid/i_out_ready : tile-side slice handshake
//   o_window_last   : current beat is the last of its window
//   o_img_done      : one-cycle pulse after the image's last window completes
//
// state  | meaning
// LOAD   | accepting pixels, buffer shifting, no slice presented
// STREAM | buffer frozen, presenting window slices to the tiles
module conv_ibuf_ctrl
   import conv_pkg::*;
#(
   parameter int DATA_SIZE      = 8,
   parameter int IMG_DIM        = 28,
   parameter int KERNEL_DIM     = 3,
   parameter int INPUT_CHANNELS = 2,
   parameter int NUM_ADDR       = 1,
   parameter int COUNT_WIDTH    = (DATA_SIZE == 1) ? 1 : $clog2(DATA_SIZE),
   parameter int ADDR_WIDTH     = (NUM_ADDR <= 1) ? 1 : $clog2(NUM_ADDR),
   parameter int POS_WIDTH      = (IMG_DIM <= 1) ? 1 : $clog2(IMG_DIM)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_valid,
   output logic                      o_ready,
   output logic [INPUT_CHANNELS-1:0] o_write_enable,
   output logic [COUNT_WIDTH-1:0]    o_count,
   output logic [ADDR_WIDTH-1:0]     o_ibuf_addr,
   output logic                      o_out_valid,
   input  logic                      i_out_ready,
   output logic                      o_window_last,
   output logic                      o_img_done
);

   generate
      if (KERNEL_DIM > IMG_DIM) begin : g_bad_kernel
         $error("conv_ibuf_ctrl: KERNEL_DIM must not exceed IMG_DIM");
      end
      if (NUM_ADDR < 1) begin : g_bad_num_addr
         $error("conv_ibuf_ctrl: NUM_ADDR must be at least 1");
      end
   endgenerate

   localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(DATA_SIZE - 1);
   localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR  = ADDR_WIDTH'(NUM_ADDR - 1);

   ibuf_ctrl_state_t state;
   ibuf_ctrl_state_t state_nxt;

   logic fire;
   logic beat;
   logic last_slice;
   logic window_done;
   logic img_end;
   logic win_at_end;

   conv_pos_counter #(
      .IMG_DIM    (IMG_DIM),
      .KERNEL_DIM (KERNEL_DIM),
      .POS_WIDTH  (POS_WIDTH)
   ) u_pos (
      .clk         (clk),
      .rst         (rst),
      .fire        (fire),
      .window_done (window_done),
      .img_end     (img_end)
   );

   assign fire           = i_valid & o_ready;
   assign o_write_enable = {INPUT_CHANNELS{fire}};
   assign beat           = o_out_valid & i_out_ready;
   assign last_slice     = (o_count == LAST_COUNT) && (o_ibuf_addr == LAST_ADDR);
   assign o_window_last  = o_out_valid & last_slice;

   always_ff @(posedge clk) begin
      if (rst) state <= LOAD;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         LOAD:    if (window_done)        state_nxt = STREAM;
         STREAM:  if (beat && last_slice) state_nxt = LOAD;
         default:                         state_nxt = LOAD;
      endcase
   end

   // o_ready is gated by rst so no pixel is taken while the controller resets.
   always_comb begin
      o_ready     = 1'b0;
      o_out_valid = 1'b0;
      case (state)
         LOAD:    o_ready     = ~rst;
         STREAM:  o_out_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         o_count     <= '0;
         o_ibuf_addr <= '0;
      end else if (beat) begin
         if (o_ibuf_addr == LAST_ADDR) begin
            o_ibuf_addr <= '0;
            o_count     <= (o_count == LAST_COUNT) ? '0 : o_count + 1'b1;
         end else begin
            o_ibuf_addr <= o_ibuf_addr + 1'b1;
         end
      end
   end

   // row/col have already wrapped by the time the window streams out, so the
   // end-of-image condition is captured at the completing fire.
   always_ff @(posedge clk) begin
      if (rst) begin
         win_at_end <= 1'b0;
         o_img_done <= 1'b0;
      end else begin
         if (window_done) win_at_end <= img_end;
         o_img_done <= beat & last_slice & win_at_end;
      end
   end

endmodule

// File: tb/tb_conv_ibuf_ctrl.sv
module tb_conv_ibuf_ctrl;
   import conv_pkg::*;

   typedef struct {
      int cnt;
      int addr;
      bit last;
      bit img_end;
   } beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Per-DUT model configuration: 0 = (4,3,2,2), 1 = defaults, 2 = (4,3,1,1)
   int cfg_img[3] = '{4, 28, 4};
   int cfg_k[3]   = '{3, 3, 3};
   int cfg_ds[3]  = '{2, 8, 1};
   int cfg_na[3]  = '{2, 1, 1};

   beat_t exp_q[3][$];
   int pix[3], acc[3], wins[3], dones[3], hc[3], ha[3];
   bit pend_done[3], have_hold[3], expect_valid[3], after_rst[3];

   // DUT A
   logic rst_a, iv_a, rdy_a, ordy_a, ov_a, last_a, done_a;
   logic [1:0] we_a;
   logic [0:0] cnt_a, addr_a;
   // DUT B
   logic rst_b, iv_b, rdy_b, ordy_b, ov_b, last_b, done_b;
   logic [1:0] we_b;
   logic [2:0] cnt_b;
   logic [0:0] addr_b;
   // DUT C
   logic rst_c, iv_c, rdy_c, ordy_c, ov_c, last_c, done_c;
   logic [1:0] we_c;
   logic [0:0] cnt_c, addr_c;

   conv_ibuf_ctrl #(.DATA_SIZE(2), .IMG_DIM(4), .KERNEL_DIM(3), .INPUT_CHANNELS(2), .NUM_ADDR(2)) u_a (
      .clk(clk), .rst(rst_a), .i_valid(iv_a), .o_ready(rdy_a), .o_write_enable(we_a),
      .o_count(cnt_a), .o_ibuf_addr(addr_a), .o_out_valid(ov_a), .i_out_ready(ordy_a),
      .o_window_last(last_a), .o_img_done(done_a));

   conv_ibuf_ctrl u_b (
      .clk(clk), .rst(rst_b), .i_valid(iv_b), .o_ready(rdy_b), .o_write_enable(we_b),
      .o_count(cnt_b), .o_ibuf_addr(addr_b), .o_out_valid(ov_b), .i_out_ready(ordy_b),
      .o_window_last(last_b), .o_img_done(done_b));

   conv_ibuf_ctrl #(.DATA_SIZE(1), .IMG_DIM(4), .KERNEL_DIM(3), .INPUT_CHANNELS(2), .NUM_ADDR(1)) u_c (
      .clk(clk), .rst(rst_c), .i_valid(iv_c), .o_ready(rdy_c), .o_write_enable(we_c),
      .o_count(cnt_c), .o_ibuf_addr(addr_c), .o_out_valid(ov_c), .i_out_ready(ordy_c),
      .o_window_last(last_c), .o_img_done(done_c));

   task automatic chk(input string name, input int d, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d got %0d expected %0d at %0t", name, d, act, exp, $time);
      end
   endtask

   // Model a newly accepted pixel: queue the beats of any window it completes.
   task automatic accept_pixel(input int d);
      int img, r, c;
      beat_t b;
      img = cfg_img[d];
      r = pix[d] / img;
      c = pix[d] % img;
      if (r >= cfg_k[d] - 1 && c >= cfg_k[d] - 1) begin
         for (int cc = 0; cc < cfg_ds[d]; cc++)
            for (int aa = 0; aa < cfg_na[d]; aa++) begin
               b.cnt = cc;
               b.addr = aa;
               b.last = (cc == cfg_ds[d] - 1) && (aa == cfg_na[d] - 1);
               b.img_end = b.last && (r == img - 1) && (c == img - 1);
               exp_q[d].push_back(b);
            end
         expect_valid[d] = 1'b1;
      end
      pix[d] = (pix[d] + 1) % (img * img);
      acc[d]++;
   endtask

   // Monitor / scoreboard for one DUT, sampled at the falling edge.
   task automatic mon(input int d, input logic rst_s, input logic iv, input logic rdy,
                      input int we, input logic ov, input logic tr, input int cnt,
                      input int addr, input logic last, input logic done);
      beat_t e;
      if (rst_s) begin
         chk("ready_in_reset", d, int'(rdy), 0);
         exp_q[d].delete();
         pix[d] = 0;
         pend_done[d] = 0;
         have_hold[d] = 0;
         expect_valid[d] = 0;
         after_rst[d] = 1;
         return;
      end
      if (after_rst[d]) begin
         chk("reset_valid", d, int'(ov), 0);
         chk("reset_img_done", d, int'(done), 0);
         chk("reset_count", d, cnt, 0);
         chk("reset_addr", d, addr, 0);
         chk("reset_ready", d, int'(rdy), 1);
         after_rst[d] = 0;
      end
      chk("write_enable", d, we, (iv && rdy) ? 3 : 0);
      if (ov) chk("ready_while_streaming", d, int'(rdy), 0);
      if (pend_done[d]) chk("img_done", d, int'(done), 1);
      else if (done) chk("img_done_spurious", d, 1, 0);
      if (done) dones[d]++;
      pend_done[d] = 0;
      if (have_hold[d]) begin
         chk("stall_valid", d, int'(ov), 1);
         chk("stall_count", d, cnt, hc[d]);
         chk("stall_addr", d, addr, ha[d]);
         have_hold[d] = 0;
      end
      if (expect_valid[d]) begin
         chk("first_beat_latency", d, int'(ov), 1);
         expect_valid[d] = 0;
      end
      if (ov && tr) begin
         if (exp_q[d].size() == 0) begin
            chk("unexpected_beat", d, 1, 0);
         end else begin
            e = exp_q[d].pop_front();
            chk("beat_count", d, cnt, e.cnt);
            chk("beat_addr", d, addr, e.addr);
            chk("window_last", d, int'(last), int'(e.last));
            if (e.last) wins[d]++;
            if (e.img_end) pend_done[d] = 1;
         end
      end else if (ov) begin
         have_hold[d] = 1;
         hc[d] = cnt;
         ha[d] = addr;
      end
      if (iv && rdy) accept_pixel(d);
   endtask

   always @(negedge clk) begin
      mon(0, rst_a, iv_a, rdy_a, int'(we_a), ov_a, ordy_a, int'(cnt_a), int'(addr_a), last_a, done_a);
      mon(1, rst_b, iv_b, rdy_b, int'(we_b), ov_b, ordy_b, int'(cnt_b), int'(addr_b), last_b, done_b);
      mon(2, rst_c, iv_c, rdy_c, int'(we_c), ov_c, ordy_c, int'(cnt_c), int'(addr_c), last_c, done_c);
   end

   function automatic bit idle(input int d, input int target);
      return acc[d] >= target && exp_q[d].size() == 0 && !pend_done[d];
   endfunction

   task automatic clear_counts(input int d);
      wins[d] = 0;
      dones[d] = 0;
   endtask

   initial begin
      int cyc, base;
      bit tog, stall_done, hit;
      for (int d = 0; d < 3; d++) begin
         pix[d] = 0; acc[d] = 0; wins[d] = 0; dones[d] = 0;
         pend_done[d] = 0; have_hold[d] = 0; expect_valid[d] = 0; after_rst[d] = 0;
      end
      rst_a = 1; rst_b = 1; rst_c = 1;
      iv_a = 0; iv_b = 0; iv_c = 0;
      ordy_a = 1; ordy_b = 1; ordy_c = 1;
      repeat (3) @(posedge clk);
      #1;
      rst_a = 0; rst_b = 0; rst_c = 0;

      // A: toggling i_valid for pixels 0-9, then full image with a 3-cycle stall at beat (0,1)
      clear_counts(0);
      cyc = 0; tog = 0; stall_done = 0;
      while (!idle(0, 16) && cyc < 400) begin
         @(posedge clk); #1; cyc++;
         if (acc[0] < 10) begin tog = !tog; iv_a = tog; end
         else iv_a = (acc[0] < 16);
         if (!stall_done && ov_a && cnt_a == 1'b0 && addr_a == 1'b1) begin
            ordy_a = 0;
            repeat (3) @(posedge clk);
            #1; cyc += 3;
            ordy_a = 1;
            stall_done = 1;
         end
      end
      iv_a = 0;
      if (cyc >= 400) chk("timeout_a1", 0, cyc, 0);
      chk("stall_seen", 0, int'(stall_done), 1);
      chk("windows_a1", 0, wins[0], win_count(4, 3));
      chk("img_done_a1", 0, dones[0], 1);

      // A: reset during beat (1,0) of the first window, then a full image
      cyc = 0; hit = 0; iv_a = 1;
      while (!hit && cyc < 100) begin
         @(posedge clk); #1; cyc++;
         if (ov_a && cnt_a == 1'b1 && addr_a == 1'b0) hit = 1;
      end
      chk("reset_point_reached", 0, int'(hit), 1);
      rst_a = 1;
      @(posedge clk); #1;
      rst_a = 0;
      clear_counts(0);
      base = acc[0]; cyc = 0;
      while (!idle(0, base + 16) && cyc < 200) begin
         iv_a = (acc[0] < base + 16);
         @(posedge clk); #1; cyc++;
      end
      iv_a = 0;
      if (cyc >= 200) chk("timeout_a2", 0, cyc, 0);
      chk("windows_a2", 0, wins[0], win_count(4, 3));
      chk("img_done_a2", 0, dones[0], 1);

      // B: default parameters, two back-to-back images
      clear_counts(1);
      cyc = 0;
      while (!idle(1, 2 * 28 * 28) && cyc < 20000) begin
         iv_b = (acc[1] < 2 * 28 * 28);
         @(posedge clk); #1; cyc++;
      end
      iv_b = 0;
      if (cyc >= 20000) chk("timeout_b", 1, cyc, 0);
      chk("windows_b", 1, wins[1], 2 * win_count(28, 3));
      chk("img_done_b", 1, dones[1], 2);

      // C: single beat per window
      clear_counts(2);
      cyc = 0;
      while (!idle(2, 16) && cyc < 200) begin
         iv_c = (acc[2] < 16);
         @(posedge clk); #1; cyc++;
      end
      iv_c = 0;
      if (cyc >= 200) chk("timeout_c", 2, cyc, 0);
      chk("windows_c", 2, wins[2], win_count(4, 3));
      chk("img_done_c", 2, dones[2], 1);

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/conv_ibuf_ctrl.md
Name: conv_ibuf_ctrl

Overview:
- Sequencer for the convolution input buffer (line-buffer FIFO plus bit-plane/address mux) feeding the CIM crossbar tiles.
- Accepts a raster-order pixel stream with all input channels in parallel and generates the buffer's per-channel shift enables.
- Tracks row/column position to detect complete KxK windows.
- For each valid window, steps the bit-plane index and the bus-address index, and presents each slice to the tile side through a valid/ready handshake.

Parameters:
DATA_SIZE, 8, activation bit width; number of bit-planes per window
IMG_DIM, 28, square input image side in pixels
KERNEL_DIM, 3, square kernel side
INPUT_CHANNELS, 2, channels written in parallel per pixel
NUM_ADDR, 1, bus-wide slices per bit-plane (must be >= 1)
COUNT_WIDTH, DATA_SIZE==1 ? 1 : clog2(DATA_SIZE), bit-plane index width
ADDR_WIDTH, NUM_ADDR<=1 ? 1 : clog2(NUM_ADDR), slice address width
POS_WIDTH, IMG_DIM<=1 ? 1 : clog2(IMG_DIM), row/column counter width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
i_valid  in  1  upstream pixel (all channels) available
o_ready  out  1  controller accepts a pixel this cycle
o_write_enable  out  INPUT_CHANNELS  buffer shift enable per channel
o_count  out  COUNT_WIDTH  bit-plane select to buffer
o_ibuf_addr  out  ADDR_WIDTH  slice select to buffer
o_out_valid  out  1  current buffer slice is valid for the tiles
i_out_ready  in  1  tiles consume slice this cycle
o_window_last  out  1  current beat is the last of its window
o_img_done  out  1  one-cycle pulse when the last window of the image completes

Behaviour:
- FSM states: LOAD, STREAM.
- Reset values (synchronous): state=LOAD, row=0, col=0, o_count=0, o_ibuf_addr=0, o_out_valid=0, o_img_done=0. o_ready=0 in any cycle where rst=1.

LOAD state:
- o_ready=1 and o_out_valid=0.
- fire = i_valid & o_ready. o_write_enable = {INPUT_CHANNELS{fire}}, combinational, with no extra register stage.
- On fire, col increments. At col==IMG_DIM-1, col wraps to 0 and row increments. At row==IMG_DIM-1 and col==IMG_DIM-1, both wrap to 0.
- A fire at position (row>=KERNEL_DIM-1, col>=KERNEL_DIM-1), tested on pre-increment values, completes a window. The next state is STREAM with o_count=0 and o_ibuf_addr=0.
- Fires that do not complete a window stay in LOAD. These are the edge columns and the first KERNEL_DIM-1 rows.

STREAM state:
- o_ready=0 and o_write_enable=0, so the FIFO is frozen. o_out_valid=1.
- First beat is presented in the cycle after the completing fire, when the FIFO already holds that pixel. Latency is therefore 1 cycle.
- Beat order: o_ibuf_addr is the inner loop (0..NUM_ADDR-1), o_count the outer loop (0..DATA_SIZE-1). Total beats per window = DATA_SIZE*NUM_ADDR.
- A beat advances only on o_out_valid & i_out_ready.
- While i_out_ready=0, all outputs hold stable (AXI-style: valid never drops before acceptance).
- o_window_last = o_out_valid & (o_count==DATA_SIZE-1) & (o_ibuf_addr==NUM_ADDR-1).
- On acceptance of the last beat: o_count=0, o_ibuf_addr=0, return to LOAD.
- If that window was at position (IMG_DIM-1, IMG_DIM-1), o_img_done=1 for exactly the following cycle. row/col are already 0, so the next image begins immediately.

Boundary conditions:
- DATA_SIZE=1 and/or NUM_ADDR=1 collapse the respective counter to a constant 0, with no width underflow.
- i_valid in STREAM is ignored. Upstream must hold the pixel because o_ready=0.
- rst asserted mid-STREAM: the next cycle is LOAD with all counters 0 and no o_img_done. The partial window is discarded.
- KERNEL_DIM > IMG_DIM is illegal; the implementation must contain a static assertion for it.
- Windows per image = (IMG_DIM-KERNEL_DIM+1)^2. Stride is 1; there is no padding.

Decomposition:
- Package conv_pkg holds:
  - typedef enum logic [0:0] {LOAD, STREAM} ibuf_ctrl_state_t
  - function win_count(img, k) returning (img-k+1)^2, for benches.
- Optional sub-module conv_pos_counter: the row/col raster counter with wrap, and the window-complete flag. Everything else lives in the top.

Test Plan:
- Config IMG_DIM=4, KERNEL_DIM=3, DATA_SIZE=2, NUM_ADDR=2, i_valid=1 and i_out_ready=1 continuously:
  - Windows complete at 0-based pixels 10, 11, 14, 15.
  - Each window gives 4 beats (count,addr) = (0,0), (0,1), (1,0), (1,1), with o_window_last on the 4th.
  - o_img_done pulses once, the cycle after the last beat of pixel 15.
- Same config, i_out_ready=0 for 3 cycles at beat (0,1): o_count=0 and o_ibuf_addr=1 hold, with o_out_valid=1 and o_write_enable=0 throughout; the beat then resumes.
- Pixels 0-9 with i_valid toggling every cycle: o_write_enable=2'b11 only on cycles where i_valid=1; no o_out_valid until after pixel 10.
- rst pulsed during beat (1,0) of the first window, then 16 pixels streamed: exactly 4 windows and one o_img_done, i.e. a full restart.
- Default parameters (28, 3, 8, 1), two back-to-back images:
  - First o_out_valid arrives 1 cycle after the 59th accepted pixel.
  - 676 windows × 8 beats per image.
  - o_img_done pulses twice.
- Config DATA_SIZE=1, NUM_ADDR=1: 1 beat per window with o_window_last=1 on every beat; o_count and o_ibuf_addr stay at 0.
